// File: rtl/fixed_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fixed_pkg                                                 |
// | Purpose  : Shared word format for the sign-magnitude fixed-point     |
// |            multiplier: field widths, word typedef, named constants.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package fixed_pkg;

  localparam int INT_BITS  = 8;
  localparam int FRAC_BITS = 8;
  localparam int W         = 1 + INT_BITS + FRAC_BITS;

  // Sign-magnitude word: value = (-1)^sign * {int_part, frac} / 2^FRAC_BITS
  typedef struct packed {
    logic                 sign;
    logic [INT_BITS-1:0]  int_part;
    logic [FRAC_BITS-1:0] frac;
  } fixed_t;

  localparam logic [W-2:0] FIXED_MAX_MAG = '1;
  localparam fixed_t       FIXED_ZERO    = '0;

endpackage
`default_nettype wire

// File: rtl/fixed_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fixed_sat                                                 |
// | Purpose  : Combinational reduction of the full magnitude product to  |
// |            one word: select the mid bits, saturate on integer        |
// |            overflow, flag discarded fraction bits, suppress -0.      |
// |            FIXED_MULT_ROUND_EN selects round-half-up instead of      |
// |            truncation.                                               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fixed_sat #(
  parameter int INT_BITS  = fixed_pkg::INT_BITS,
  parameter int FRAC_BITS = fixed_pkg::FRAC_BITS
) (
  input  logic                             sign_in,
  input  logic [2*(INT_BITS+FRAC_BITS)-1:0] prod,
  output logic [INT_BITS+FRAC_BITS:0]      word_out,
  output logic                             clip_int,
  output logic                             clip_frac
);

  localparam int MAG_W  = INT_BITS + FRAC_BITS;
  localparam int PROD_W = 2 * MAG_W;

  logic [MAG_W-1:0] mag_trunc;
  logic             ovf_hi;
  logic [MAG_W-1:0] mag_final;
`ifdef FIXED_MULT_ROUND_EN
  logic [MAG_W:0]   mag_round;
`endif

  // Select result magnitude, detect overflow / precision loss, apply sign
  always_comb begin
    mag_trunc = prod[FRAC_BITS +: MAG_W];
    ovf_hi    = |prod[PROD_W-1 : FRAC_BITS+MAG_W];
    clip_frac = |prod[FRAC_BITS-1:0];
`ifdef FIXED_MULT_ROUND_EN
    // Half-up: add the first discarded bit; a carry out also saturates
    mag_round = {1'b0, mag_trunc} + {{MAG_W{1'b0}}, prod[FRAC_BITS-1]};
    clip_int  = ovf_hi | mag_round[MAG_W];
    mag_final = clip_int ? {MAG_W{1'b1}} : mag_round[MAG_W-1:0];
`else
    clip_int  = ovf_hi;
    mag_final = ovf_hi ? {MAG_W{1'b1}} : mag_trunc;
`endif
    // A zero magnitude is always reported with a positive sign
    word_out  = {sign_in & (|mag_final), mag_final};
  end

endmodule
`default_nettype wire

// File: rtl/fixed_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fixed_mult                                                |
// | Purpose  : Two-stage pipelined sign-magnitude fixed-point multiplier |
// |            with saturation and clip flags. Latency 2, one op/cycle.  |
// |            Optional build macro: FIXED_MULT_ROUND_EN (round half-up).|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fixed_mult #(
  parameter int INT_BITS  = fixed_pkg::INT_BITS,
  parameter int FRAC_BITS = fixed_pkg::FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [INT_BITS+FRAC_BITS:0] a,
  input  logic [INT_BITS+FRAC_BITS:0] b,
  output logic                        out_valid,
  output logic [INT_BITS+FRAC_BITS:0] ab,
  output logic                        clip_int,
  output logic                        clip_frac
);

  import fixed_pkg::*;

  localparam int MAG_W  = INT_BITS + FRAC_BITS;
  localparam int WORD_W = MAG_W + 1;
  localparam int PROD_W = 2 * MAG_W;

  // Stage 1 registers
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic              in_valid_q, in_valid_d;

  // Stage 2 registers
  logic [WORD_W-1:0] ab_q, ab_d;
  logic              clip_int_q, clip_int_d;
  logic              clip_frac_q, clip_frac_d;
  logic              out_valid_q, out_valid_d;

  // Multiply path between the stages
  logic [PROD_W-1:0] prod;
  logic              prod_sign;
  logic [WORD_W-1:0] sat_word;
  logic              sat_clip_int;
  logic              sat_clip_frac;

  // Stage 1 next state: capture operands every cycle
  always_comb begin
    a_d        = a;
    b_d        = b;
    in_valid_d = in_valid;
  end

  // Stage 1 flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      in_valid_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      in_valid_q <= in_valid_d;
    end
  end

  // Unsigned magnitude product and XOR sign; a -0 operand gives a zero product
  always_comb begin
    prod      = {{MAG_W{1'b0}}, a_q[MAG_W-1:0]} * {{MAG_W{1'b0}}, b_q[MAG_W-1:0]};
    prod_sign = a_q[WORD_W-1] ^ b_q[WORD_W-1];
  end

  fixed_sat #(
    .INT_BITS  (INT_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat (
    .sign_in   (prod_sign),
    .prod      (prod),
    .word_out  (sat_word),
    .clip_int  (sat_clip_int),
    .clip_frac (sat_clip_frac)
  );

  // Stage 2 next state: load on a valid op, otherwise hold the last result
  always_comb begin
    out_valid_d = in_valid_q;
    ab_d        = ab_q;
    clip_int_d  = clip_int_q;
    clip_frac_d = clip_frac_q;
    if (in_valid_q) begin
      ab_d        = sat_word;
      clip_int_d  = sat_clip_int;
      clip_frac_d = sat_clip_frac;
    end
  end

  // Stage 2 flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ab_q        <= '0;
      clip_int_q  <= 1'b0;
      clip_frac_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ab_q        <= ab_d;
      clip_int_q  <= clip_int_d;
      clip_frac_q <= clip_frac_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ab        = ab_q;
  assign clip_int  = clip_int_q;
  assign clip_frac = clip_frac_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fixed_mult                                             |
// | Purpose  : Self-checking bench for fixed_mult: directed vectors,     |
// |            randomized traffic against an arithmetic reference model, |
// |            back-to-back ops, bubbles and mid-flight reset.           |
// |            Honors FIXED_MULT_ROUND_EN for the expected rounding.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_fixed_mult;

  localparam int W = fixed_pkg::W;

  typedef struct {
    bit           v;
    logic [W-1:0] ab;
    logic         ci;
    logic         cf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic [W-1:0] ab;
  logic         clip_int;
  logic         clip_frac;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  exp_t         pend[$];
  logic [W-1:0] last_ab = '0;
  logic         last_ci = 1'b0;
  logic         last_cf = 1'b0;

  fixed_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .ab        (ab),
    .clip_int  (clip_int),
    .clip_frac (clip_frac)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Reference: real-number semantics with integer arithmetic
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t        e;
    longint      ma, mb, p, m;
    bit          neg;
    ma  = longint'(xa[W-2:0]);
    mb  = longint'(xb[W-2:0]);
    p   = ma * mb;                  // value * 2^16
    m   = p / 256;                  // keep 8 fraction bits
    e.cf = (p % 256) != 0;
    e.ci = (m > 65535);
`ifdef FIXED_MULT_ROUND_EN
    m = m + ((p / 128) % 2);
    if (m > 65535) e.ci = 1'b1;
`endif
    if (e.ci) m = 65535;
    neg  = (xa[W-1] != xb[W-1]) && (m != 0);
    e.ab = {neg, 16'(m)};
    e.v  = 1'b1;
    return e;
  endfunction

  // Present one op (or bubble) and check the output that leaves this edge
  task automatic step(input bit v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input exp_t e, input string tag);
    exp_t x;
    @(negedge clk);
    in_valid = v;
    a = xa;
    b = xb;
    e.v = v;
    pend.push_back(e);
    @(posedge clk);
    #1;
    if (pend.size() > 1) begin
      x = pend.pop_front();
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(x.v));
      if (x.v) begin
        last_ab = x.ab;
        last_ci = x.ci;
        last_cf = x.cf;
      end
      chk({tag, ".ab"},        32'(ab),        32'(last_ab));
      chk({tag, ".clip_int"},  32'(clip_int),  32'(last_ci));
      chk({tag, ".clip_frac"}, 32'(clip_frac), 32'(last_cf));
    end
  endtask

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb, input string tag);
    step(1'b1, xa, xb, model(xa, xb), tag);
  endtask

  task automatic dir(input logic [W-1:0] xa, input logic [W-1:0] xb,
                     input logic [W-1:0] want_ab, input logic ci, input logic cf,
                     input string tag);
    exp_t e;
    e.v  = 1'b1;
    e.ab = want_ab;
    e.ci = ci;
    e.cf = cf;
    step(1'b1, xa, xb, e, tag);
  endtask

  task automatic bubble(input string tag);
    exp_t e;
    e.v  = 1'b0;
    e.ab = '0;
    e.ci = 1'b0;
    e.cf = 1'b0;
    step(1'b0, '0, '0, e, tag);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".ab"},        32'(ab),        32'd0);
    chk({tag, ".clip_int"},  32'(clip_int),  32'd0);
    chk({tag, ".clip_frac"}, 32'(clip_frac), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           rv;

    // Power-on reset, checked before any clock edge
    #1 rst = 1'b1;
    #1 check_cleared("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    dir(17'h00200, 17'h00200, 17'h00400, 1'b0, 1'b0, "p2xp2");
    dir(17'h10200, 17'h00200, 17'h10400, 1'b0, 1'b0, "m2xp2");
    dir(17'h10200, 17'h10200, 17'h00400, 1'b0, 1'b0, "m2xm2");
    dir(17'h01000, 17'h01000, 17'h0FFFF, 1'b1, 1'b0, "ovf_pos");
    dir(17'h11000, 17'h01000, 17'h1FFFF, 1'b1, 1'b0, "ovf_neg");
`ifdef FIXED_MULT_ROUND_EN
    dir(17'h10001, 17'h00080, 17'h10001, 1'b0, 1'b1, "frac_loss");
`else
    dir(17'h10001, 17'h00080, 17'h00000, 1'b0, 1'b1, "frac_loss");
`endif
    dir(17'h10000, 17'h10200, 17'h00000, 1'b0, 1'b0, "neg_zero_in");
    dir(17'h1FFFF, 17'h00100, 17'h1FFFF, 1'b0, 1'b0, "max_x_one");

    // Bubbles: outputs hold while out_valid is low
    bubble("bubble0");
    bubble("bubble1");
    bubble("bubble2");

    // Three back-to-back ops, results in order
    op(17'h00180, 17'h00300, "b2b0");
    op(17'h10040, 17'h00A00, "b2b1");
    op(17'h00333, 17'h10111, "b2b2");
    bubble("b2b_drain0");
    bubble("b2b_drain1");

    // Randomized traffic, mixing wide and small magnitudes
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ra[W-2:0] = 16'($urandom_range(0, 16'h0FFF));
        rb[W-2:0] = 16'($urandom_range(0, 16'h0FFF));
      end
      if (rv) op(ra, rb, "rand");
      else    bubble("rand_bubble");
    end
    bubble("rand_drain0");
    bubble("rand_drain1");

    // Reset with two operations in flight
    dir(17'h00200, 17'h00200, 17'h00400, 1'b0, 1'b0, "pre_rst0");
    op(17'h00F00, 17'h00F00, "pre_rst1");
    @(negedge clk);
    in_valid = 1'b1;
    a = 17'h00300;
    b = 17'h00300;
    #2 rst = 1'b1;
    #1 check_cleared("rst_async");
    pend.delete();
    last_ab = '0;
    last_ci = 1'b0;
    last_cf = 1'b0;
    @(posedge clk);
    #1 check_cleared("rst_held");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    bubble("post_rst0");
    bubble("post_rst1");
    bubble("post_rst2");

    // Normal operation resumes after reset
    dir(17'h00200, 17'h10200, 17'h10400, 1'b0, 1'b0, "post_rst_op");
    bubble("final_drain0");
    bubble("final_drain1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
